// File: rtl/lcd_cmd_arbiter.sv
// lcd_cmd_arbiter
// Shares the single LCD command writer between the image generator's
// command sources (init sequence, frame update, redraw loop, game-over).
// Requester 0 has fixed top priority; requesters 1..NUM_REQ-1 are served
// round-robin. A programmable idle gap follows every completed command.
//
// Optional feature macro: LCD_ARB_TIMEOUT_EN
//   defined   : watchdog aborts a BUSY phase after TIMEOUT_CYCLES and sets
//               the sticky timeout_err flag.
//   undefined : BUSY waits for cmd_done forever, timeout_err is tied 0.
//
// Ports
//   clk          system clock, rising edge
//   nrst         synchronous active-low reset
//   sync_clear   synchronous soft clear (same effect as reset)
//   req          per-requester request level, held until req_done
//   cmd_in       flattened command words, slice i belongs to req[i]
//   cmd_done     writer-finished pulse
//   grant        one-hot owner of the writer, 0 when free
//   cmd_out      latched command word of the owner
//   cmd_start    one-cycle launch pulse to the writer
//   req_done     one-cycle completion pulse to the owner
//   busy         high in every state except IDLE
//   timeout_err  sticky watchdog flag
//
// state | meaning
// IDLE  | writer free, arbitrate on req
// ISSUE | cmd_start pulse cycle
// BUSY  | waiting for cmd_done (or watchdog)
// GAP   | forced idle cycles after completion

module lcd_cmd_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int CMD_W          = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     sync_clear,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CMD_W-1:0] cmd_in,
    input  logic                     cmd_done,
    output logic [NUM_REQ-1:0]       grant,
    output logic [CMD_W-1:0]         cmd_out,
    output logic                     cmd_start,
    output logic [NUM_REQ-1:0]       req_done,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [GAP_W-1:0]   gap_cnt;
    logic [IDX_W-1:0]   win_idx;
    logic               win_vld;
    logic               complete;
    int                 cand;

`ifdef LCD_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]    to_cnt;
    logic               to_hit;
    logic               to_err_q;
    assign to_hit      = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign complete    = cmd_done || to_hit;
    assign timeout_err = to_err_q;
`else
    assign complete    = cmd_done;
    assign timeout_err = 1'b0;
`endif

    // Winner: req[0] first, otherwise first set bit at/after rr_ptr within
    // indices 1..NUM_REQ-1, wrapping back to 1.
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        cand    = 0;
        if (req[0]) begin
            win_vld = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ - 1; k++) begin
                cand = ((int'(rr_ptr) - 1 + k) % (NUM_REQ - 1)) + 1;
                if (!win_vld && req[cand]) begin
                    win_vld = 1'b1;
                    win_idx = IDX_W'(cand);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst || sync_clear) begin
            state     <= IDLE;
            rr_ptr    <= IDX_W'(1);
            gap_cnt   <= '0;
            grant     <= '0;
            cmd_out   <= '0;
            cmd_start <= 1'b0;
            req_done  <= '0;
            busy      <= 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
            to_cnt    <= '0;
            to_err_q  <= 1'b0;
`endif
        end else begin
            cmd_start <= 1'b0;
            req_done  <= '0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant     <= NUM_REQ'(1) << win_idx;
                        cmd_out   <= cmd_in[win_idx*CMD_W +: CMD_W];
                        cmd_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                        if (win_idx != '0) begin
                            if (int'(win_idx) == NUM_REQ - 1)
                                rr_ptr <= IDX_W'(1);
                            else
                                rr_ptr <= win_idx + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state <= BUSY;
`ifdef LCD_ARB_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end
                BUSY: begin
                    if (complete) begin
                        req_done <= grant;
                        grant    <= '0;
                        if (GAP_CYCLES > 0) begin
                            gap_cnt <= GAP_W'(GAP_LOAD);
                            state   <= GAP;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
`ifdef LCD_ARB_TIMEOUT_EN
                        // A cmd_done in the expiry cycle wins: no error.
                        if (!cmd_done)
                            to_err_q <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
module tb_lcd_cmd_arbiter;

    localparam int NUM_REQ = 4;
    localparam int CMD_W   = 8;

    logic                     tb_clk = 1'b0;
    logic                     nrst;
    logic                     sync_clear;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CMD_W-1:0] cmd_in;
    logic                     cmd_done;
    logic [NUM_REQ-1:0]       grant;
    logic [CMD_W-1:0]         cmd_out;
    logic                     cmd_start;
    logic [NUM_REQ-1:0]       req_done;
    logic                     busy;
    logic                     timeout_err;

    int checks = 0;
    int errors = 0;

    // expected {grant, cmd_out} of every launch, in order
    logic [11:0] exp_q[$];

    always #5 tb_clk = ~tb_clk;

    lcd_cmd_arbiter #(
        .NUM_REQ(NUM_REQ), .CMD_W(CMD_W), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(tb_clk), .nrst(nrst), .sync_clear(sync_clear), .req(req),
        .cmd_in(cmd_in), .cmd_done(cmd_done), .grant(grant), .cmd_out(cmd_out),
        .cmd_start(cmd_start), .req_done(req_done), .busy(busy),
        .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    // scoreboard consumer: every launch must match the next expectation
    always begin
        @(posedge tb_clk);
        #1;
        if (cmd_start === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_start", {20'd0, grant, cmd_out}, 32'hFFFF_FFFF);
            end else begin
                chk("launch", {20'd0, grant, cmd_out}, {20'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic finish_cmd(input logic [NUM_REQ-1:0] owner);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        chk("req_done", req_done, owner);
        chk("grant_free", grant, 0);
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (grant == '0 && n < 30) begin
            tick();
            n++;
        end
        if (n >= 30) chk("grant_wait_expired", n, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        if (n >= 30) chk("idle_wait_expired", n, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "simulation hung");
    end

    initial begin
        int n;
        nrst = 1'b0; sync_clear = 1'b0; cmd_done = 1'b0;
        req = 4'b1111;
        cmd_in = {8'h44, 8'h33, 8'h22, 8'h11};

        // reset with all requests held
        tick(); tick();
        chk("rst_grant", grant, 0);
        chk("rst_cmd_out", cmd_out, 0);
        chk("rst_start", cmd_start, 0);
        chk("rst_req_done", req_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout_err, 0);
        exp_q.push_back({4'b0001, 8'h11});
        nrst = 1'b1;
        tick();
        chk("first_start", cmd_start, 1);
        req = 4'b0000;
        tick();
        chk("start_one_cycle", cmd_start, 0);
        tick();
        finish_cmd(4'b0001);
        wait_idle();

        // single requester 2, cmd_in change after grant is ignored
        cmd_in[23:16] = 8'hA5;
        exp_q.push_back({4'b0100, 8'hA5});
        req = 4'b0100;
        tick();
        chk("r2_grant", grant, 4'b0100);
        cmd_in[23:16] = 8'h5A;
        tick();
        chk("r2_cmd_hold", cmd_out, 8'hA5);
        tick(); tick(); tick();
        finish_cmd(4'b0100);
        req = 4'b0000;
        tick();
        chk("busy_gap1", busy, 1);
        chk("req_done_pulse", req_done, 0);
        tick();
        chk("busy_gap_end", busy, 0);

        // round-robin among 1..3 from a fresh pointer
        sync_clear = 1'b1;
        tick();
        sync_clear = 1'b0;
        cmd_in = {8'hD3, 8'hC2, 8'hB1, 8'h00};
        exp_q.push_back({4'b0010, 8'hB1});
        exp_q.push_back({4'b0100, 8'hC2});
        exp_q.push_back({4'b1000, 8'hD3});
        exp_q.push_back({4'b0010, 8'hB1});
        req = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            wait_grant(n);
            if (i > 0) chk("rr_gap_latency", n, 3);
            tick(); tick();
            if (i == 3) req = 4'b0000;
            finish_cmd(grant);
        end
        wait_idle();

        // requester 0 always beats a pending requester 3
        cmd_in = {8'hE3, 8'hC2, 8'hB1, 8'h77};
        req = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({4'b0001, 8'h77});
            wait_grant(n);
            chk("prio_grant", grant, 4'b0001);
            tick();
            finish_cmd(4'b0001);
        end
        req = 4'b1000;
        exp_q.push_back({4'b1000, 8'hE3});
        wait_grant(n);
        chk("r3_after_r0", grant, 4'b1000);
        req = 4'b0000;
        tick();
        finish_cmd(4'b1000);
        wait_idle();

        // hung writer
        exp_q.push_back({4'b0010, 8'hB1});
        req = 4'b0010;
        wait_grant(n);
`ifdef LCD_ARB_TIMEOUT_EN
        req = 4'b0000;
        n = 0;
        while (req_done == '0 && n < 40) begin
            tick();
            n++;
        end
        chk("wd_latency", n, 17);
        chk("wd_req_done", req_done, 4'b0010);
        chk("wd_grant", grant, 0);
        chk("wd_err", timeout_err, 1);
        wait_idle();
        chk("wd_err_sticky", timeout_err, 1);
        sync_clear = 1'b1;
        tick();
        sync_clear = 1'b0;
        chk("wd_err_clear", timeout_err, 0);
        exp_q.push_back({4'b0010, 8'hB1});
        req = 4'b0010;
        wait_grant(n);
        tick(); tick();
`else
        for (int i = 0; i < 40; i++) tick();
        chk("hung_grant_held", grant, 4'b0010);
        chk("hung_no_err", timeout_err, 0);
`endif

        // sync_clear while BUSY, later cmd_done ignored
        chk("pre_clear_busy", busy, 1);
        sync_clear = 1'b1;
        req = 4'b0000;
        tick();
        sync_clear = 1'b0;
        chk("clr_busy", busy, 0);
        chk("clr_grant", grant, 0);
        chk("clr_start", cmd_start, 0);
        chk("clr_req_done", req_done, 0);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        chk("stray_done_req_done", req_done, 0);
        tick();
        chk("stray_done_busy", busy, 0);
        chk("stray_done_grant", grant, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
